// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if: serial line input and received-byte outputs of the UART receiver.
`timescale 1ns/1ps
`default_nettype none

interface uart_rx_byte_if;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_dv;
    logic       o_frame_err;
    logic       o_busy;

    modport master (
        input  i_rx,
        output o_data,
        output o_dv,
        output o_frame_err,
        output o_busy
    );

    modport slave (
        output i_rx,
        input  o_data,
        input  o_dv,
        input  o_frame_err,
        input  o_busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART receiver, mid-bit sampling, byte/frame-error strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  wire logic       clk,
    input  wire logic       i_reset_n,
    uart_rx_byte_if.master  bus
);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_rx_byte: CLKS_PER_BIT out of range 4..65535");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("uart_rx_byte: SYNC_STAGES out of range 2..4");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_half = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_clk_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic [7:0]             r_data;
    logic                   r_dv;
    logic                   r_frame_err;
    logic                   r_busy;
    logic                   w_rx_s;

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // Synchronizer presets high so reset looks like an idle line, not a start bit.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_rx};
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_dv        <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_dv        <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_clk_cnt == c_half) begin
                        r_clk_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_one;
                    end
                end
                S_DATA: begin
                    if (r_clk_cnt == c_last) begin
                        r_clk_cnt          <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_one;
                    end
                end
                S_STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch a gapless next start.
                    if (r_clk_cnt == c_last) begin
                        r_clk_cnt <= '0;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        if (w_rx_s) begin
                            r_data <= r_shift;
                            r_dv   <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_one;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_data      = r_data;
    assign bus.o_dv        = r_dv;
    assign bus.o_frame_err = r_frame_err;
    assign bus.o_busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: line-level UART transmitter model feeding a scoreboard of expected strobes.
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_byte;

    localparam int  CPB     = 16;
    localparam int  SYNC    = 2;
    localparam real CLK_NS  = 10.0;
    localparam real BIT_NS  = CPB * CLK_NS;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        realtime    t0;
        logic       timed;
    } exp_t;

    logic clk;
    logic rst_n;
    uart_rx_byte_if bus ();

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk       (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_dv = 1'b0;
    logic       prev_fe = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmits one 8N1 frame; the expectation is queued when the stop bit starts.
    task automatic send_frame(input logic [7:0] b, input logic stop, input real bit_ns, input logic timed);
        exp_t e;
        e.t0      = $realtime;
        e.timed   = timed;
        bus.i_rx  = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            bus.i_rx = b[i];
            #(bit_ns);
        end
        bus.i_rx = stop;
        if (stop) begin
            last_good = b;
            e.is_err  = 1'b0;
            e.data    = b;
        end else begin
            e.is_err  = 1'b1;
            e.data    = last_good;
        end
        sb.push_back(e);
        #(bit_ns);
        bus.i_rx = 1'b1;
        if (!stop) #(2.0 * bit_ns);
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while (sb.size() != 0 && waited < 40 * CPB) begin
            @(posedge clk);
            waited++;
        end
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (!rst_n) begin
            prev_dv = 1'b0;
            prev_fe = 1'b0;
        end else begin
            if (bus.o_dv || bus.o_frame_err) begin
                chk("strobe_exclusive", {31'd0, bus.o_dv & bus.o_frame_err}, 0);
                chk("strobe_width", {31'd0, (bus.o_dv & prev_dv) | (bus.o_frame_err & prev_fe)}, 0);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: dv=%0b frame_err=%0b data=%0h with nothing expected",
                             bus.o_dv, bus.o_frame_err, bus.o_data);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_kind_frame_err", {31'd0, bus.o_frame_err}, {31'd0, e.is_err});
                    chk("rx_data", {24'd0, bus.o_data}, {24'd0, e.data});
                    if (bus.o_dv) chk("busy_falls_with_dv", {31'd0, bus.o_busy}, 0);
                    if (e.timed) begin
                        lat = $rtoi(($realtime - e.t0) / CLK_NS);
                        chk("latency_in_window", {31'd0, (lat >= 154 && lat <= 158)}, 1);
                    end
                end
            end
            prev_dv = bus.o_dv;
            prev_fe = bus.o_frame_err;
        end
    end

    initial begin
        logic [7:0] b;
        logic [7:0] seq [6];
        seq[0] = 8'h01; seq[1] = 8'h12; seq[2] = 8'h01;
        seq[3] = 8'h23; seq[4] = 8'h34; seq[5] = 8'h56;

        bus.i_rx = 1'b1;
        rst_n    = 1'b0;
        #23;
        chk("reset_data", {24'd0, bus.o_data}, 0);
        chk("reset_dv", {31'd0, bus.o_dv}, 0);
        chk("reset_frame_err", {31'd0, bus.o_frame_err}, 0);
        chk("reset_busy", {31'd0, bus.o_busy}, 0);
        rst_n = 1'b1;
        #(2.0 * BIT_NS);

        // Single ideal frame; busy must be up shortly after the start edge.
        fork
            send_frame(8'hA5, 1'b1, BIT_NS, 1'b1);
            begin
                #(8.0 * CLK_NS);
                chk("busy_after_start", {31'd0, bus.o_busy}, 1);
            end
        join
        drain("drain_a5");

        // Six gapless frames.
        for (int i = 0; i < 6; i++) send_frame(seq[i], 1'b1, BIT_NS, 1'b1);
        drain("drain_b2b");

        // Bad stop bit: frame error, o_data must hold 8'h56.
        send_frame(8'h3C, 1'b0, BIT_NS, 1'b0);
        drain("drain_frame_err");

        // 5-cycle glitch: false start, busy gone within half a bit plus pipeline.
        #(BIT_NS);
        bus.i_rx = 1'b0;
        #(5.0 * CLK_NS);
        bus.i_rx = 1'b1;
        #((CPB / 2 + 2 + SYNC + 2) * CLK_NS);
        chk("glitch_busy_cleared", {31'd0, bus.o_busy}, 0);
        #(BIT_NS);
        send_frame(8'hFF, 1'b1, BIT_NS, 1'b1);
        drain("drain_after_glitch");

        // Reset asserted during data bit 4.
        #(BIT_NS);
        b = 8'hC3;
        bus.i_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            bus.i_rx = b[i];
            #(BIT_NS);
        end
        bus.i_rx = b[4];
        #(BIT_NS / 2.0 + 3.0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", {31'd0, bus.o_busy}, 0);
        chk("async_reset_data", {24'd0, bus.o_data}, 0);
        chk("async_reset_dv", {31'd0, bus.o_dv}, 0);
        last_good = 8'h00;
        bus.i_rx  = 1'b1;
        #(4.0 * CLK_NS);
        rst_n = 1'b1;
        #(2.0 * BIT_NS);
        send_frame(8'h5A, 1'b1, BIT_NS, 1'b1);
        drain("drain_after_reset");

        // Transmitter rate skew of +/-4%.
        send_frame(8'h55, 1'b1, BIT_NS * 1.04, 1'b0);
        #(BIT_NS);
        send_frame(8'hAA, 1'b1, BIT_NS * 0.96, 1'b0);
        drain("drain_skew");

        // Randomized frames with occasional bad stop bits and random idle gaps.
        for (int i = 0; i < 30; i++) begin
            b = 8'($urandom);
            send_frame(b, ($urandom_range(0, 7) != 0), BIT_NS, 1'b1);
            #($urandom_range(0, 2) * BIT_NS);
        end
        drain("drain_random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
